// File: rtl/multicast_bus_driver.sv
// multicast_bus_driver: programs a controller scan chain with IDs, then drives tagged words onto a shared bus
module multicast_bus_driver #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int BITWIDTH      = 16,
    parameter int NUM_UNITS     = 4
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               cfg_start,
    input  logic [NUM_UNITS*ADDRESS_WIDTH-1:0] cfg_ids,
    output logic                               program_en,
    output logic [ADDRESS_WIDTH-1:0]           scan_tag_out,
    output logic                               cfg_done,
    input  logic                               in_valid,
    input  logic [ADDRESS_WIDTH-1:0]           in_tag,
    input  logic [BITWIDTH-1:0]                in_value,
    output logic                               in_ready,
    input  logic                               stop,
    output logic                               enable,
    output logic [ADDRESS_WIDTH-1:0]           tag,
    output logic [BITWIDTH-1:0]                value,
    input  logic                               bus_ready,
    output logic [15:0]                        sent_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROG = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [4:0] LAST = 5'(NUM_UNITS - 1);

    logic [1:0]                         state;
    logic [4:0]                         cnt;
    logic [NUM_UNITS*ADDRESS_WIDTH-1:0] ids_q;
    logic                               stop_pending;
    logic                               accept;
    logic                               done;

    // The latched table shifts up one slice per PROG cycle, so its top slice is always the next ID to send
    assign program_en   = state == PROG;
    assign scan_tag_out = program_en ? ids_q[NUM_UNITS*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH] : '0;
    assign in_ready     = state == RUN && (!enable || bus_ready) && !stop_pending;
    assign accept       = in_valid && in_ready;
    assign done         = enable && bus_ready;

    // Sequencer: IDLE -> PROG for NUM_UNITS shifts -> RUN until a requested stop has drained the bus
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            cnt          <= '0;
            ids_q        <= '0;
            cfg_done     <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: if (cfg_start) begin
                    ids_q <= cfg_ids;
                    cnt   <= '0;
                    state <= PROG;
                end
                PROG: begin
                    ids_q <= ids_q << ADDRESS_WIDTH;
                    cnt   <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        cfg_done <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: if (stop_pending && !enable) begin
                    stop_pending <= 1'b0;
                    state        <= IDLE;
                end else if (stop) begin
                    stop_pending <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus register: a new word replaces the old one, a completion without replacement drops enable, a stall holds
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            enable     <= 1'b0;
            tag        <= '0;
            value      <= '0;
            sent_count <= '0;
        end else begin
            sent_count <= sent_count + {15'd0, done};
            if (accept) begin
                enable <= 1'b1;
                tag    <= in_tag;
                value  <= in_value;
            end else if (done) begin
                enable <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multicast_bus_driver.sv
// tb_multicast_bus_driver: directed table-driven check of scan programming, bus handshake, stop and reset
module tb_multicast_bus_driver;
    localparam int AW = 4;
    localparam int BW = 16;
    localparam int NU = 4;

    logic           clk = 1'b0;
    logic           rstb = 1'b1;
    logic           cfg_start = 1'b0;
    logic [NU*AW-1:0] cfg_ids = '0;
    logic           program_en;
    logic [AW-1:0]  scan_tag_out;
    logic           cfg_done;
    logic           in_valid = 1'b0;
    logic [AW-1:0]  in_tag = '0;
    logic [BW-1:0]  in_value = '0;
    logic           in_ready;
    logic           stop = 1'b0;
    logic           enable;
    logic [AW-1:0]  tag;
    logic [BW-1:0]  value;
    logic           bus_ready = 1'b0;
    logic [15:0]    sent_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] pos [NU];
    logic [NU-1:0] uen;

    multicast_bus_driver #(.ADDRESS_WIDTH(AW), .BITWIDTH(BW), .NUM_UNITS(NU)) dut (
        .clk(clk), .rstb(rstb), .cfg_start(cfg_start), .cfg_ids(cfg_ids),
        .program_en(program_en), .scan_tag_out(scan_tag_out), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_tag(in_tag), .in_value(in_value), .in_ready(in_ready),
        .stop(stop), .enable(enable), .tag(tag), .value(value),
        .bus_ready(bus_ready), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    // Chained controllers: head is position 0, IDs shift toward the far end while program is high
    initial for (int k = 0; k < NU; k++) pos[k] = '0;
    always @(posedge clk) begin
        if (program_en) begin
            pos[0] <= scan_tag_out;
            for (int k = 1; k < NU; k++) pos[k] <= pos[k-1];
        end
    end

    always_comb begin
        uen = '0;
        for (int k = 0; k < NU; k++) uen[k] = enable && (tag == pos[k]);
    end

    typedef struct packed {
        logic          iv;
        logic [3:0]    t;
        logic [15:0]   v;
        logic          br;
        logic          ir;
        logic          en;
        logic [3:0]    et;
        logic [15:0]   ev;
        logic [15:0]   cnt;
        logic [3:0]    uen;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //          iv    tag    value      br    ir    en    etag   evalue     count   uen
        tbl[0]  = '{1'b1, 4'd3, 16'd257,  1'b1, 1'b1, 1'b1, 4'd3, 16'd257,  16'd1 - 16'd1, 4'b1000};
        tbl[1]  = '{1'b0, 4'd0, 16'd0,    1'b1, 1'b1, 1'b0, 4'd3, 16'd257,  16'd1, 4'b0000};
        tbl[2]  = '{1'b1, 4'd2, 16'd512,  1'b0, 1'b1, 1'b1, 4'd2, 16'd512,  16'd1, 4'b0100};
        tbl[3]  = '{1'b1, 4'd5, 16'd999,  1'b0, 1'b0, 1'b1, 4'd2, 16'd512,  16'd1, 4'b0100};
        tbl[4]  = '{1'b1, 4'd5, 16'd999,  1'b0, 1'b0, 1'b1, 4'd2, 16'd512,  16'd1, 4'b0100};
        tbl[5]  = '{1'b1, 4'd5, 16'd999,  1'b0, 1'b0, 1'b1, 4'd2, 16'd512,  16'd1, 4'b0100};
        tbl[6]  = '{1'b0, 4'd0, 16'd0,    1'b1, 1'b1, 1'b0, 4'd2, 16'd512,  16'd2, 4'b0000};
        tbl[7]  = '{1'b1, 4'd1, 16'h0011, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0011, 16'd2, 4'b0010};
        tbl[8]  = '{1'b1, 4'd2, 16'h0022, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0022, 16'd3, 4'b0100};
        tbl[9]  = '{1'b1, 4'd3, 16'h0033, 1'b1, 1'b1, 1'b1, 4'd3, 16'h0033, 16'd4, 4'b1000};
        tbl[10] = '{1'b1, 4'd0, 16'h0044, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0044, 16'd5, 4'b0001};
        tbl[11] = '{1'b0, 4'd0, 16'd0,    1'b1, 1'b1, 1'b0, 4'd0, 16'h0044, 16'd6, 4'b0000};
        tbl[12] = '{1'b1, 4'd7, 16'hABCD, 1'b0, 1'b1, 1'b1, 4'd7, 16'hABCD, 16'd6, 4'b0000};

        #1 rstb = 1'b0;
        #1;
        chk("rst program", program_en, 0);
        chk("rst scan_tag", scan_tag_out, 0);
        chk("rst cfg_done", cfg_done, 0);
        chk("rst enable", enable, 0);
        chk("rst tag", tag, 0);
        chk("rst value", value, 0);
        chk("rst sent_count", sent_count, 0);
        chk("rst in_ready", in_ready, 0);

        @(negedge clk);
        rstb = 1'b1;
        in_valid = 1'b1;
        bus_ready = 1'b1;
        stop = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle program", program_en, 0);
        chk("idle in_ready", in_ready, 0);
        chk("idle enable", enable, 0);

        stop = 1'b0;
        in_valid = 1'b0;
        cfg_ids = 16'h3210;
        cfg_start = 1'b1;
        for (int c = 0; c < NU; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("prog%0d program", c), program_en, 1);
            chk($sformatf("prog%0d scan_tag", c), scan_tag_out, 32'(3 - c));
            chk($sformatf("prog%0d cfg_done", c), cfg_done, 0);
            chk($sformatf("prog%0d in_ready", c), in_ready, 0);
            if (c == 0) cfg_start = 1'b0;
            if (c == 1) begin
                cfg_start = 1'b1;
                cfg_ids = 16'hFFFF;
            end
        end
        @(posedge clk);
        #1;
        chk("cfg_done pulse", cfg_done, 1);
        chk("run program", program_en, 0);
        chk("run scan_tag", scan_tag_out, 0);
        @(posedge clk);
        #1;
        chk("cfg_done one cycle", cfg_done, 0);
        chk("run cfg_start ignored", program_en, 0);
        for (int k = 0; k < NU; k++) chk($sformatf("chain pos%0d", k), pos[k], 32'(k));
        cfg_start = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_tag    = tbl[i].t;
            in_value  = tbl[i].v;
            bus_ready = tbl[i].br;
            #1;
            chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].ir);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d enable", i), enable, tbl[i].en);
            chk($sformatf("v%0d tag", i), tag, tbl[i].et);
            chk($sformatf("v%0d value", i), value, tbl[i].ev);
            chk($sformatf("v%0d sent_count", i), sent_count, tbl[i].cnt);
            chk($sformatf("v%0d unit_enable", i), uen, tbl[i].uen);
        end

        @(negedge clk);
        stop = 1'b1;
        bus_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("stop stall enable", enable, 1);
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("stop stall in_ready", in_ready, 0);
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        chk("stop pending in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("stop drain enable", enable, 0);
        chk("stop drain count", sent_count, 7);
        chk("stop drain tag", tag, 7);
        @(negedge clk);
        #1;
        chk("stop drained in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("stop no accept", enable, 0);
        in_valid = 1'b0;

        @(negedge clk);
        cfg_ids = 16'h5678;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        chk("reprog program", program_en, 1);
        chk("reprog scan0", scan_tag_out, 5);
        @(posedge clk);
        #1;
        chk("reprog scan1", scan_tag_out, 6);
        #3 rstb = 1'b0;
        #1;
        chk("async rst program", program_en, 0);
        chk("async rst scan_tag", scan_tag_out, 0);
        chk("async rst enable", enable, 0);
        chk("async rst tag", tag, 0);
        chk("async rst value", value, 0);
        chk("async rst sent_count", sent_count, 0);
        chk("async rst cfg_done", cfg_done, 0);
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post rst idle program", program_en, 0);
        chk("post rst idle in_ready", in_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicast_bus_driver.md
MULTICAST_BUS_DRIVER -- requirements
Module: multicast_bus_driver

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4: width of tag IDs and bus tag.
REQ-002 SHALL have parameter BITWIDTH, default 16: width of the data value carried on the bus.
REQ-003 SHALL have parameter NUM_UNITS, default 4: number of multicast controllers on the scan chain (2..16).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstb, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_start, input, 1: request to program the scan chain.
REQ-007 SHALL have port cfg_ids, input, NUM_UNITS*ADDRESS_WIDTH: ID table; slice k is the ID for chain position k (0 = nearest driver).
REQ-008 SHALL have port program, output, 1: scan-chain shift enable to all controllers.
REQ-009 SHALL have port scan_tag_out, output, ADDRESS_WIDTH: serial ID into chain head.
REQ-010 SHALL have port cfg_done, output, 1: one-cycle pulse when programming completes.
REQ-011 SHALL have port in_valid, input, 1: upstream (tag, value) available.
REQ-012 SHALL have port in_tag, input, ADDRESS_WIDTH: destination tag.
REQ-013 SHALL have port in_value, input, BITWIDTH: payload.
REQ-014 SHALL have port in_ready, output, 1: driver accepts the upstream word this cycle.
REQ-015 SHALL have port stop, input, 1: request return to IDLE after drain.
REQ-016 SHALL have port enable, output, 1: bus word valid; drives all controller enables.
REQ-017 SHALL have port tag, output, ADDRESS_WIDTH: bus tag.
REQ-018 SHALL have port value, output, BITWIDTH: bus payload.
REQ-019 SHALL have port bus_ready, input, 1: AND of unit_ready of all targeted units.
REQ-020 SHALL have port sent_count, output, 16: count of completed bus transfers.

Function
REQ-021 SHALL implement FSM states IDLE, PROG, RUN; reset state IDLE.
REQ-022 IDLE: program=0, enable=0, in_ready=0; cfg_start=1 -> latch cfg_ids, clear shift counter, go PROG.
REQ-023 PROG: program=1 for exactly NUM_UNITS consecutive cycles; on shift cycle c (0..NUM_UNITS-1), scan_tag_out = latched slice NUM_UNITS-1-c, so the farthest ID enters first.
REQ-024 After last shift cycle -> RUN, program=0, cfg_done=1 for exactly one cycle; cfg_start and cfg_ids changes during PROG ignored.
REQ-025 scan_tag_out SHALL be 0 whenever program=0.
REQ-026 RUN: in_ready = (!enable || bus_ready) && !stop_pending.
REQ-027 in_valid && in_ready: register in_tag/in_value onto tag/value, enable=1 next cycle (latency 1).
REQ-028 enable && bus_ready with no new acceptance: enable=0 next cycle; tag/value hold last word.
REQ-029 enable && !bus_ready: tag, value, enable SHALL hold unchanged (stall).
REQ-030 Transfer completes on every cycle with enable && bus_ready; sent_count increments by 1, wraps 0xFFFF -> 0; cleared only by reset.
REQ-031 Simultaneous completion and acceptance: new word replaces old with enable staying 1 (back-to-back, one word/cycle).
REQ-032 stop=1 in RUN sets stop_pending; once enable=0 (drained) -> IDLE, stop_pending cleared; stop in IDLE/PROG ignored.
REQ-033 cfg_start in RUN ignored; reprogramming requires stop first.
REQ-034 in_ready SHALL be 0 in IDLE and PROG.

Reset
REQ-035 rstb=0 SHALL immediately, without clock, force state IDLE, program=0, scan_tag_out=0, cfg_done=0, enable=0, tag=0, value=0, sent_count=0, stop_pending=0, shift counter=0.
REQ-036 Reset asserted mid-PROG or mid-stall SHALL abort; no partial transfer counted; after release, driver idles until cfg_start.

Verification
REQ-037 cfg_start with cfg_ids={3,2,1,0} (slice3..slice0), NUM_UNITS=4 -> program=1 for 4 cycles, scan_tag_out = 3,2,1,0; cfg_done pulse on 5th cycle; four chained controllers hold IDs 0,1,2,3 at positions 0..3.
REQ-038 RUN, bus_ready=1, in_valid with (tag=3,value=257) -> next cycle enable=1, tag=3, value=257; controller with ID 3 asserts unit_enable, others do not; sent_count=1.
REQ-039 bus_ready=0 for 3 cycles with (tag=2,value=512) on bus -> in_ready=0, bus holds 2/512, sent_count unchanged; bus_ready=1 -> transfer counts once.
REQ-040 in_valid held 1 with 4 words, bus_ready=1 -> 4 words on 4 consecutive cycles, sent_count +4.
REQ-041 stop during stall -> in_ready=0, state RUN until bus_ready completes word, then IDLE; rstb pulse mid-PROG -> all outputs 0 asynchronously.
